// File: rtl/fifo_ram_ctrl_if.sv
// Push/pop valid-ready handshake bundle for the FIFO RAM controller.
// master: datapath side (drives push, consumes pop). slave: controller side.
interface fifo_ram_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  push_valid;
    logic                  push_ready;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  pop_valid;
    logic                  pop_ready;
    logic [DATA_WIDTH-1:0] pop_data;

    modport master (
        output push_valid,
        output push_data,
        output pop_ready,
        input  push_ready,
        input  pop_valid,
        input  pop_data
    );

    modport slave (
        input  push_valid,
        input  push_data,
        input  pop_ready,
        output push_ready,
        output pop_valid,
        output pop_data
    );
endinterface

// File: rtl/fifo_ram_ctrl.sv
// FIFO controller for a dual-port RAM with a registered show-ahead output stage.
// Ports: i_clk, i_reset_n (async low), i_flush, io_fifo (push/pop handshake),
//   o_count/o_full/o_empty, RAM port 0 (write) o_address_0/o_chip_enable_0/
//   o_write_read_0/o_data_0, RAM port 1 (read) o_address_1/o_chip_enable_1/
//   o_write_read_1/i_data_1.
// Option FIFO_CTRL_ALMOST_EN adds registered o_almost_full/o_almost_empty.
module fifo_ram_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    parameter int AF_LEVEL = (2 ** ADDR_WIDTH) - 2,
    parameter int AE_LEVEL = 2
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_flush,
    fifo_ram_ctrl_if.slave        io_fifo,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH-1:0] o_address_0,
    output logic                  o_chip_enable_0,
    output logic                  o_write_read_0,
    output logic [DATA_WIDTH-1:0] o_data_0,
    output logic [ADDR_WIDTH-1:0] o_address_1,
    output logic                  o_chip_enable_1,
    output logic                  o_write_read_1,
    input  logic [DATA_WIDTH-1:0] i_data_1
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic                  o_almost_full,
    output logic                  o_almost_empty
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    out_state_t            r_state;
    out_state_t            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_cnt;
    logic [ADDR_WIDTH:0]   w_ram_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_pop_data;

    logic w_ram_nz;
    logic w_full;
    logic w_push_ready;
    logic w_wr_en;
    logic w_pop_valid;
    logic w_pop_fire;
    logic w_load;

    // Read side only trusts the registered RAM count, so a word written
    // this cycle is never read before the next one.
    assign w_ram_nz     = (r_ram_cnt != '0);
    assign w_full       = (r_ram_cnt == DEPTH);
    assign w_push_ready = !w_full;
    assign w_pop_valid  = (r_state == OUT_FULL);
    assign w_pop_fire   = w_pop_valid && io_fifo.pop_ready;

    // Write strobe is killed by flush and while reset is held.
    assign w_wr_en = io_fifo.push_valid && w_push_ready
                     && !i_flush && i_reset_n;

    always_comb begin
        w_state_nxt = r_state;
        w_load      = w_ram_nz && (!w_pop_valid || io_fifo.pop_ready);
        unique case (r_state)
            OUT_EMPTY: begin
                if (w_load) w_state_nxt = OUT_FULL;
            end
            OUT_FULL: begin
                if (w_pop_fire && !w_load) w_state_nxt = OUT_EMPTY;
            end
            default: w_state_nxt = OUT_EMPTY;
        endcase
        if (i_flush) begin
            w_state_nxt = OUT_EMPTY;
            w_load      = 1'b0;
        end
    end

    always_comb begin
        w_ram_cnt_nxt = r_ram_cnt
                        + (ADDR_WIDTH + 1)'(w_wr_en)
                        - (ADDR_WIDTH + 1)'(w_load);
        if (i_flush) w_ram_cnt_nxt = '0;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_pop_data <= '0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_ram_cnt  <= '0;
            r_pop_data <= '0;
        end else begin
            r_wr_ptr  <= r_wr_ptr + ADDR_WIDTH'(w_wr_en);
            r_rd_ptr  <= r_rd_ptr + ADDR_WIDTH'(w_load);
            r_ram_cnt <= w_ram_cnt_nxt;
            if (w_load) r_pop_data <= i_data_1;
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    localparam logic [ADDR_WIDTH:0] AF_L = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [ADDR_WIDTH:0] w_count_nxt;
    logic                r_almost_full;
    logic                r_almost_empty;

    assign w_count_nxt = w_ram_cnt_nxt
                         + (ADDR_WIDTH + 1)'(w_state_nxt == OUT_FULL);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_count_nxt >= AF_L);
            r_almost_empty <= (w_count_nxt <= AE_L);
        end
    end

    assign o_almost_full  = r_almost_full;
    assign o_almost_empty = r_almost_empty;
`endif

    assign io_fifo.push_ready = w_push_ready;
    assign io_fifo.pop_valid  = w_pop_valid;
    assign io_fifo.pop_data   = r_pop_data;

    assign o_count = r_ram_cnt + (ADDR_WIDTH + 1)'(w_pop_valid);
    assign o_full  = w_full;
    assign o_empty = (o_count == '0);

    assign o_address_0     = r_wr_ptr;
    assign o_chip_enable_0 = w_wr_en;
    assign o_write_read_0  = w_wr_en;
    assign o_data_0        = io_fifo.push_data;

    assign o_address_1     = r_rd_ptr;
    assign o_chip_enable_1 = w_ram_nz;
    assign o_write_read_1  = 1'b0;

endmodule
